// File: rtl/spi_master.sv
// spi_master: single-channel SPI master, mode 0 (sck idles low, data sampled
// on the rising edge), MSB first.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_data [MAX_LEN]    transmit bits, right-justified; bit len-1 goes first
//   req_len  [7]          bit count, 0 = empty transfer, clamps to MAX_LEN
//   req_ss                index of the slave select to drive low
//   rsp_valid/rsp_ready   response handshake
//   rsp_data [MAX_LEN]    received bits, right-justified, upper bits zero
//   sck, ss, mosi, miso   serial pins (idle: sck=0, ss=all ones, mosi=1)
module spi_master #(
  parameter int DIV     = 2,
  parameter int SS_W    = 8,
  parameter int MAX_LEN = 64,
  localparam int IDX_W  = (SS_W > 1) ? $clog2(SS_W) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [MAX_LEN-1:0] req_data,
  input  logic [6:0]         req_len,
  input  logic [IDX_W-1:0]   req_ss,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               sck,
  output logic [SS_W-1:0]    ss,
  output logic               mosi,
  input  logic               miso
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int PH_W  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_RESP
  } state_t;

  state_t             state, state_nxt;
  logic [PH_W-1:0]    ph_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [MAX_LEN-1:0] tx;
  logic [MAX_LEN-1:0] rx;
  logic [IDX_W-1:0]   ss_idx;
  logic               ss_act;
  logic [6:0]         len_c;
  logic [6:0]         tx_sh;
  logic               phase_last;
  logic               accept;

  assign len_c      = (req_len > 7'(MAX_LEN)) ? 7'(MAX_LEN) : req_len;
  // Left-align the request so the first bit sits in the MSB; bits at and
  // above len fall off the top.
  assign tx_sh      = 7'(MAX_LEN) - len_c;
  assign phase_last = (ph_cnt == PH_W'(DIV - 1));
  assign accept     = req_valid && req_ready;
  assign rsp_data   = rx;
  assign ss         = ss_act ? ~(SS_W'(1) << ss_idx) : {SS_W{1'b1}};

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    sck       = 1'b0;
    ss_act    = 1'b0;
    mosi      = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = (len_c == 7'd0) ? S_RESP : S_SETUP;
      end
      S_SETUP: begin
        ss_act = 1'b1;
        mosi   = tx[MAX_LEN-1];
        if (phase_last) state_nxt = S_HIGH;
      end
      S_HIGH: begin
        sck    = 1'b1;
        ss_act = 1'b1;
        mosi   = tx[MAX_LEN-1];
        if (phase_last) state_nxt = (bit_cnt == CNT_W'(1)) ? S_HOLD : S_LOW;
      end
      S_LOW: begin
        ss_act = 1'b1;
        mosi   = tx[MAX_LEN-1];
        if (phase_last) state_nxt = S_HIGH;
      end
      S_HOLD: begin
        ss_act = 1'b1;
        mosi   = tx[MAX_LEN-1];
        if (phase_last) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: begin
        // Pins idle; ready stays low so no request is swallowed during recovery.
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ph_cnt  <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      ss_idx  <= '0;
    end else begin
      if (state == S_SETUP || state == S_HIGH || state == S_LOW || state == S_HOLD)
        ph_cnt <= phase_last ? '0 : ph_cnt + PH_W'(1);
      else
        ph_cnt <= '0;

      if (state == S_IDLE && accept) begin
        tx      <= req_data << tx_sh;
        rx      <= '0;
        bit_cnt <= CNT_W'(len_c);
        ss_idx  <= req_ss;
      end

      // Sample miso just before sck falls; advance tx only when another bit
      // follows so mosi holds the last bit through HOLD.
      if (state == S_HIGH && phase_last) begin
        rx      <= {rx[MAX_LEN-2:0], miso};
        bit_cnt <= bit_cnt - CNT_W'(1);
        if (bit_cnt != CNT_W'(1)) tx <= tx << 1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master. DUT u_dut (DIV=2) runs in loopback
// (miso = mosi); u_dut1 (DIV=1) sees a slave that always returns 1.
// Stimulus pushes hand-computed expectations; one negedge monitor does all
// comparisons.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // u_dut, DIV=2, loopback
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_data, rsp_data;
  logic [6:0]  req_len;
  logic [2:0]  req_ss;
  logic        sck, mosi, miso;
  logic [7:0]  ss;
  assign miso = mosi;

  // u_dut1, DIV=1, slave returns constant 1
  logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
  logic [63:0] r1_req_data, r1_rsp_data;
  logic [6:0]  r1_req_len;
  logic [2:0]  r1_req_ss;
  logic        sck1, mosi1;
  logic [7:0]  ss1;

  spi_master #(.DIV(2), .SS_W(8), .MAX_LEN(64)) u_dut (
    .clock(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_len(req_len), .req_ss(req_ss),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_master #(.DIV(1), .SS_W(8), .MAX_LEN(64)) u_dut1 (
    .clock(clk), .reset(rst),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_data(r1_req_data),
    .req_len(r1_req_len), .req_ss(r1_req_ss),
    .rsp_valid(r1_rsp_valid), .rsp_ready(r1_rsp_ready), .rsp_data(r1_rsp_data),
    .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(1'b1)
  );

  typedef struct {
    logic [63:0] rsp;
    int          idx;
    int          lat;
    int          edges;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp1_q[$];

  int n_vec  = 0;
  int n_fail = 0;

  // stimulus-owned
  int to_req   = 0;
  bit done_req = 1'b0;

  // monitor-owned
  int          ncyc    = 0;
  int          acc_cyc = 0;
  int          edges   = 0;
  int          ss_cyc  = 0;
  int          ss_bad  = 0;
  int          last_hs = -10;
  logic [63:0] mosi_cap = '0;
  bit          in_xfer = 1'b0, rsp_seen = 1'b0, sck_prev = 1'b0, rst_prev = 1'b0;
  int          acc1 = 0, e1cnt = 0, hi1 = 0;
  bit          x1 = 1'b0, prev1 = 1'b0;
  bit          done_ack = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   first;
    ncyc++;

    // Reset was applied at the preceding posedge: pins must be idle.
    if (rst_prev) begin
      chk("rst_pins", {req_ready, rsp_valid, sck, mosi, ss},
          {1'b1, 1'b0, 1'b0, 1'b1, 8'hFF});
      chk("rst_rsp_data", rsp_data, 64'h0);
      chk("rst_pins_d1", {r1_req_ready, r1_rsp_valid, sck1, mosi1, ss1},
          {1'b1, 1'b0, 1'b0, 1'b1, 8'hFF});
    end
    rst_prev = rst;

    if (rst) begin
      in_xfer  = 1'b0;
      rsp_seen = 1'b0;
      x1       = 1'b0;
    end else begin
      // ---- u_dut ----
      if (req_valid && req_ready) begin
        acc_cyc  = ncyc;
        in_xfer  = 1'b1;
        edges    = 0;
        ss_cyc   = 0;
        ss_bad   = 0;
        mosi_cap = '0;
        sck_prev = 1'b0;
      end else if (in_xfer && !rsp_valid) begin
        if (sck && !sck_prev) begin
          edges++;
          mosi_cap = {mosi_cap[62:0], mosi};
        end
        sck_prev = sck;
        if (ss != 8'hFF) begin
          ss_cyc++;
          if (exp_q.size() > 0 && ss != ~(8'(1) << exp_q[0].idx)) ss_bad++;
        end
      end

      if (ncyc == last_hs + 1) chk("ready_after_rsp", req_ready, 1'b1);

      if (rsp_valid) begin
        first    = !rsp_seen;
        rsp_seen = 1'b1;
        chk("rsp_pins", {req_ready, sck, mosi, ss}, {1'b0, 1'b0, 1'b1, 8'hFF});
        if (first) chk("rsp_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          chk("rsp_data", rsp_data, e.rsp);
          if (first) begin
            chk("latency", ncyc - acc_cyc, e.lat);
            chk("sck_edges", edges, e.edges);
            chk("mosi_seq", mosi_cap, e.rsp);
            chk("ss_low_cycles", ss_cyc, (e.edges == 0) ? 0 : e.lat - 1);
            chk("ss_wrong_line", ss_bad, 0);
          end
        end
        if (rsp_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          rsp_seen = 1'b0;
          in_xfer  = 1'b0;
          last_hs  = ncyc;
        end
      end

      // ---- u_dut1 ----
      if (r1_req_valid && r1_req_ready) begin
        acc1  = ncyc;
        x1    = 1'b1;
        e1cnt = 0;
        hi1   = 0;
        prev1 = 1'b0;
      end else if (x1 && !r1_rsp_valid) begin
        if (sck1) hi1++;
        if (sck1 && !prev1) e1cnt++;
        prev1 = sck1;
      end
      if (r1_rsp_valid && x1) begin
        chk("d1_rsp_expected", exp1_q.size() > 0, 1'b1);
        if (exp1_q.size() > 0) begin
          e = exp1_q.pop_front();
          chk("d1_rsp_data", r1_rsp_data, e.rsp);
          chk("d1_latency", ncyc - acc1, e.lat);
          chk("d1_sck_edges", e1cnt, e.edges);
          chk("d1_sck_high_cycles", hi1, e.edges);
        end
        x1 = 1'b0;
      end
    end

    if (done_req && !done_ack) begin
      chk("pending_rsp", exp_q.size() + exp1_q.size(), 0);
      chk("wait_timeouts", to_req, 0);
      done_ack = 1'b1;
    end
  end

  // All stimulus tasks start and end at posedge+#1.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input int len, input int idx,
                      input logic [63:0] exp_rsp, input int lat, input int edg,
                      input bit keep, input bit exp_en);
    exp_t e;
    int   n;
    req_data  = d;
    req_len   = 7'(len);
    req_ss    = 3'(idx);
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 1000);
    if (!req_ready) to_req++;
    else if (exp_en) begin
      e.rsp = exp_rsp; e.idx = idx; e.lat = lat; e.edges = edg;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp1_q.size() != 0) to_req++;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   n, cnt;
    bit   prev;
    req_valid = 1'b0; req_data = '0; req_len = '0; req_ss = '0; rsp_ready = 1'b1;
    r1_req_valid = 1'b0; r1_req_data = '0; r1_req_len = '0; r1_req_ss = '0;
    r1_rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step(2);

    // loopback, DIV=2
    send(64'hA5, 8, 3, 64'hA5, 35, 8, 1'b0, 1'b1);                  wait_idle();
    send(64'h5A3, 12, 0, 64'h5A3, 51, 12, 1'b0, 1'b1);              wait_idle();
    send(64'hFFFF_FF12, 4, 7, 64'h2, 19, 4, 1'b0, 1'b1);            wait_idle();

    // constant-1 slave, DIV=1, len=64
    r1_req_data = '0; r1_req_len = 7'd64; r1_req_ss = 3'd0; r1_req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!r1_req_ready && n < 100);
    if (!r1_req_ready) to_req++;
    else begin
      e.rsp = {64{1'b1}}; e.idx = 0; e.lat = 130; e.edges = 64;
      exp1_q.push_back(e);
    end
    @(posedge clk); #1;
    r1_req_valid = 1'b0;
    wait_idle();

    // empty transfer and over-length clamp
    send(64'hDEAD, 0, 5, 64'h0, 1, 0, 1'b0, 1'b1);                  wait_idle();
    send(64'h0123_4567_89AB_CDEF, 100, 1, 64'h0123_4567_89AB_CDEF, 259, 64,
         1'b0, 1'b1);                                               wait_idle();

    // backpressure: response held 10 cycles while a new request waits
    rsp_ready = 1'b0;
    send(64'h96, 8, 2, 64'h96, 35, 8, 1'b0, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 200);
    if (!rsp_valid) to_req++;
    @(posedge clk); #1;
    req_data = 64'h7E; req_len = 7'd8; req_ss = 3'd6; req_valid = 1'b1;
    step(9);
    rsp_ready = 1'b1;
    send(64'h7E, 8, 6, 64'h7E, 35, 8, 1'b0, 1'b1);                  wait_idle();

    // back-to-back with req_valid held high
    send(64'h11, 8, 4, 64'h11, 35, 8, 1'b1, 1'b1);
    send(64'h22, 8, 5, 64'h22, 35, 8, 1'b0, 1'b1);                  wait_idle();

    // reset during the 4th HIGH phase aborts without a response
    send(64'hF0, 8, 3, 64'h0, 0, 0, 1'b0, 1'b0);
    cnt = 0; prev = 1'b0; n = 0;
    while (cnt < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (sck && !prev) cnt++;
      prev = sck;
    end
    if (cnt < 4) to_req++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    step(50);
    send(64'h3C, 8, 3, 64'h3C, 35, 8, 1'b0, 1'b1);                  wait_idle();

    step(3);
    done_req = 1'b1;
    n = 0;
    while (!done_ack && n < 10) begin
      @(posedge clk);
      n++;
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-channel SPI master (mode 0, MSB first) that drives the serial side of on-board SPI slave peripherals such as the bit-reverse device.
- The CPU/bus side issues one transfer per request over a valid/ready handshake. The block returns the received bits through a second valid/ready handshake.
- Sits between the peripheral crossbar adapter and the external sck/ss/mosi/miso pins.

Parameters:
- DIV, 2, sck half-period in clock cycles (≥1).
- SS_W, 8, number of slave-select lines.
- MAX_LEN, 64, maximum bits per transfer; also the width of the data buses.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  transfer request valid
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_data  in  MAX_LEN  transmit bits, right-justified; bit len-1 is sent first
- req_len  in  7  bit count; 0 = empty transfer; values >MAX_LEN clamp to MAX_LEN
- req_ss  in  $clog2(SS_W)  slave index to select
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  MAX_LEN  received bits, right-justified; upper bits zero
- sck  out  1  serial clock, idles low
- ss  out  SS_W  active-low selects, idle all-ones
- mosi  out  1  serial out, idles 1
- miso  in  1  serial in

Behaviour:
- Reset, synchronous, active-high; takes effect regardless of state, including mid-transfer:
  - state=IDLE, sck=0, ss=all 1, mosi=1, req_ready=1, rsp_valid=0, rsp_data=0, counters=0.
  - A transfer aborted by reset produces no response.
- Request acceptance: handshake on req_valid&&req_ready. The block latches data, len (clamped) and ss index, then drops req_ready on the next cycle.
- States and transitions:
  - IDLE: req_ready=1. On accept with len=0 -> RESP directly; no ss/sck activity; rsp_data=0. Otherwise -> SETUP.
  - SETUP: ss[idx]=0, mosi=bit len-1, sck=0, held DIV cycles -> HIGH.
  - HIGH: sck=1 for DIV cycles. On the last cycle of the phase, miso is sampled and shifted into the rx register LSB. If bits remain -> LOW; else -> HOLD.
  - LOW: sck=0 for DIV cycles. mosi updates to the next bit on entry (the same edge sck falls) -> HIGH.
  - HOLD: sck=0, ss still asserted, mosi keeps the last bit, DIV cycles -> RESP.
  - RESP: ss=all 1, mosi=1, rsp_valid=1, rsp_data = rx register. Holds until rsp_ready=1, then -> IDLE, rsp_valid=0 next cycle.
- Timing:
  - mosi only changes while sck is low or falling. miso is sampled before the falling edge, so the slave may update miso on the rising edge.
  - Latency: rsp_valid first high exactly DIV*(2*len+1)+1 cycles after the accept cycle (len≥1). For len=0, 1 cycle.
  - Exactly len rising sck edges per transfer. ss stays low continuously from SETUP through HOLD.
- req_valid during a transfer is ignored (req_ready=0); no queueing.
- rsp_data and rsp_valid are stable while rsp_valid && !rsp_ready.
- Invalid state encoding -> IDLE with outputs at idle values.
- Width rules:
  - Bit counter is wide enough for MAX_LEN and counts down from len.
  - Phase counter counts 0..DIV-1.
  - Bits of req_data at and above len are ignored.

Test Plan:
- Loopback (mosi tied to miso), DIV=2, len=8, data=0xA5, ss=3 -> mosi sequence 1,0,1,0,0,1,0,1; 8 sck rising edges; only ss[3] low; rsp_data=0x00000000000000A5; rsp_valid exactly 35 cycles after accept.
- Bench slave model returning constant 1, len=64, data=0, DIV=1 -> rsp_data=all ones; 64 sck pulses each 1 cycle high; rsp_valid 130 cycles after accept.
- len=0 and len=100: len=0 -> no ss/sck activity, rsp_data=0 one cycle after accept; len=100 -> behaves as len=64.
- Backpressure: rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_valid/rsp_data stable, req_ready=0, new req_valid not accepted; one cycle after rsp_ready=1 -> req_ready=1.
- Reset asserted during the 4th HIGH phase -> next cycle sck=0, ss=0xFF, mosi=1, req_ready=1; no rsp_valid ever; a following len=8 loopback transfer with data 0x3C returns 0x3C.
- Back-to-back transfers with req_valid held high and rsp_ready=1 -> second request accepted one cycle after the first response handshake; ss deasserted for at least 1 cycle between transfers.
